// File: rtl/sq_acc_pkg.sv
// Shared types, widths and the saturating adder for the sum-of-squares stage.
package sq_acc_pkg;

  localparam int IN_W  = 3;
  localparam int SQ_W  = 6;
  localparam int MAX_W = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] sum;
  } sat_t;

  // Adds two non-negative values and clamps the result to (2^width)-1.
  // The ovf bit reports that clamping happened.
  function automatic sat_t sat_add(input logic [MAX_W-1:0] acc,
                                   input logic [MAX_W-1:0] sq,
                                   input int               width);
    logic [MAX_W:0] s;
    logic [MAX_W:0] lim;
    sat_t           r;
    s   = {1'b0, acc} + {1'b0, sq};
    lim = ({{MAX_W{1'b0}}, 1'b1} << width) - {{MAX_W{1'b0}}, 1'b1};
    if (s > lim) begin
      r.ovf = 1'b1;
      r.sum = lim[MAX_W-1:0];
    end else begin
      r.ovf = 1'b0;
      r.sum = s[MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sq_accumulator_if.sv
// Operand input and result output handshakes of the sum-of-squares stage.
interface sq_accumulator_if
  import sq_acc_pkg::*;
#(
  parameter int ACC_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  // The accumulator stage itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/sq_accumulator_sq3_lut.sv
// Combinational 3-bit to 6-bit squarer implemented as a lookup table.
module sq3_lut
  import sq_acc_pkg::*;
(
  input  logic [IN_W-1:0] a,
  output logic [SQ_W-1:0] sq
);

  // Table lookup of a*a.
  always_comb begin
    sq = '0;
    case (a)
      3'd0:    sq = 6'd0;
      3'd1:    sq = 6'd1;
      3'd2:    sq = 6'd4;
      3'd3:    sq = 6'd9;
      3'd4:    sq = 6'd16;
      3'd5:    sq = 6'd25;
      3'd6:    sq = 6'd36;
      3'd7:    sq = 6'd49;
      default: sq = 6'd0;
    endcase
  end

endmodule

// File: rtl/sq_accumulator.sv
// Accumulates the squares of N_TERMS operands into a saturating sum and
// presents each frame result on a valid/ready output before rearming.
module sq_accumulator
  import sq_acc_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  sq_accumulator_if.slave  bus,
  output logic [CNT_W-1:0] term_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_d;
  logic             ovf;
  logic             ovf_d;
  logic [CNT_W-1:0] cnt_d;
  logic             load;
  logic             armed;

  logic [SQ_W-1:0]  sq;
  sat_t             add_res;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;
  logic             in_fire;
  logic             out_fire;
  logic             last;

  sq3_lut u_lut (
    .a  (bus.in_data),
    .sq (sq)
  );

  assign add_res  = sat_add(MAX_W'(acc), MAX_W'(sq), ACC_W);
  assign acc_nxt  = add_res.sum[ACC_W-1:0];
  assign ovf_nxt  = ovf | add_res.ovf;

  // in_ready stays low until the first clock edge after reset release.
  assign bus.in_ready  = armed && (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = bus.out_valid && bus.out_ready;
  assign last          = (term_cnt == CNT_W'(N_TERMS - 1));

  // Next-state and datapath update; clr overrides both handshakes.
  always_comb begin
    state_nxt = state;
    acc_d     = acc;
    ovf_d     = ovf;
    cnt_d     = term_cnt;
    load      = 1'b0;
    if (clr) begin
      state_nxt = ACCUM;
      acc_d     = '0;
      ovf_d     = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_fire) begin
            acc_d = acc_nxt;
            ovf_d = ovf_nxt;
            cnt_d = term_cnt + CNT_W'(1);
            if (last) begin
              load      = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            state_nxt = ACCUM;
            acc_d     = '0;
            ovf_d     = 1'b0;
            cnt_d     = '0;
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // State register plus the one-shot arming flag for in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // Running sum, sticky overflow and term counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      ovf      <= 1'b0;
      term_cnt <= '0;
    end else begin
      acc      <= acc_d;
      ovf      <= ovf_d;
      term_cnt <= cnt_d;
    end
  end

  // Result registers: loaded on the last operand, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_sum <= '0;
      bus.out_ovf <= 1'b0;
    end else if (load) begin
      bus.out_sum <= acc_nxt;
      bus.out_ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_sq_accumulator.sv
// Bench for sq_accumulator: an 8-bit and a 6-bit accumulator share one
// stimulus stream and are checked against a frame-level model every cycle.
module tb_sq_accumulator;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic [2:0] in_data;
  logic       out_ready;
  logic [7:0] cnt8;
  logic [7:0] cnt6;

  int n_total;
  int n_pass;

  sq_accumulator_if #(.ACC_W(8)) bus8 ();
  sq_accumulator_if #(.ACC_W(6)) bus6 ();

  assign bus8.in_valid  = in_valid;
  assign bus8.in_data   = in_data;
  assign bus8.out_ready = out_ready;
  assign bus6.in_valid  = in_valid;
  assign bus6.in_data   = in_data;
  assign bus6.out_ready = out_ready;

  sq_accumulator #(.N_TERMS(N), .ACC_W(8), .CNT_W(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .bus      (bus8.slave),
    .term_cnt (cnt8)
  );

  sq_accumulator #(.N_TERMS(N), .ACC_W(6), .CNT_W(8)) dut6 (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .bus      (bus6.slave),
    .term_cnt (cnt6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int clamp(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // Frame-level model: count accepted operands, sum their squares, and
  // hold one pending result until it is taken.
  int m_cnt;
  int m_total;
  bit m_pend;
  bit m_armed;
  int m_sum8, m_sum6;
  bit m_ovf8, m_ovf6;

  initial begin
    m_cnt = 0; m_total = 0; m_pend = 0; m_armed = 0;
    m_sum8 = 0; m_sum6 = 0; m_ovf8 = 0; m_ovf6 = 0;
    forever begin
      bit rdy;
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 0; m_total = 0; m_pend = 0; m_armed = 0;
        m_sum8 = 0; m_sum6 = 0; m_ovf8 = 0; m_ovf6 = 0;
      end else begin
        rdy = m_armed && !m_pend;
        m_armed = 1;
        if (clr) begin
          m_cnt = 0; m_total = 0; m_pend = 0;
        end else if (m_pend) begin
          if (out_ready) begin
            m_cnt = 0; m_total = 0; m_pend = 0;
          end
        end else if (in_valid && rdy) begin
          m_total = m_total + int'(in_data) * int'(in_data);
          m_cnt   = m_cnt + 1;
          if (m_cnt == N) begin
            m_pend = 1;
            m_sum8 = clamp(m_total, 8);
            m_ovf8 = (m_total > 255);
            m_sum6 = clamp(m_total, 6);
            m_ovf6 = (m_total > 63);
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("rdy8", int'(bus8.in_ready), int'(m_armed && !m_pend));
      chk("rdy6", int'(bus6.in_ready), int'(m_armed && !m_pend));
      chk("vld8", int'(bus8.out_valid), int'(m_pend));
      chk("vld6", int'(bus6.out_valid), int'(m_pend));
      chk("cnt8", int'(cnt8), m_cnt);
      chk("cnt6", int'(cnt6), m_cnt);
      if (m_pend) begin
        chk("sum8", int'(bus8.out_sum), m_sum8);
        chk("ovf8", int'(bus8.out_ovf), int'(m_ovf8));
        chk("sum6", int'(bus6.out_sum), m_sum6);
        chk("ovf6", int'(bus6.out_ovf), int'(m_ovf6));
      end
    end
  end

  // Offers one operand and waits (bounded) for it to be accepted.
  task automatic feed_one(input int v, input int gap);
    bit r;
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = 3'(v);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      r = bus8.in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic feed_frame(input int v[4], input int gap);
    for (int i = 0; i < 4; i++) feed_one(v[i], (i == 3) ? 0 : gap);
  endtask

  // Hand-computed result check, taken the cycle after the last operand.
  task automatic check_res(input string nm, input int s8, input int o8,
                           input int s6, input int o6);
    chk({nm, "_vld"},  int'(bus8.out_valid), 1);
    chk({nm, "_sum8"}, int'(bus8.out_sum), s8);
    chk({nm, "_ovf8"}, int'(bus8.out_ovf), o8);
    chk({nm, "_sum6"}, int'(bus6.out_sum), s6);
    chk({nm, "_ovf6"}, int'(bus6.out_ovf), o6);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_vld", int'(bus8.out_valid), 0);
    chk("rst_sum", int'(bus8.out_sum), 0);
    chk("rst_cnt", int'(cnt8), 0);
    chk("rst_rdy", int'(bus8.in_ready), 0);
    repeat (3) step();
    rst = 1'b0;
    chk("rel_rdy0", int'(bus8.in_ready), 0);
    step();
    chk("rel_rdy1", int'(bus8.in_ready), 1);

    // Back-to-back frames.
    feed_frame('{1, 2, 3, 7}, 0);
    check_res("f1237", 63, 0, 63, 0);
    step();
    chk("f1237_rearm", int'(bus8.in_ready), 1);
    chk("f1237_drop", int'(bus8.out_valid), 0);
    feed_frame('{7, 7, 7, 7}, 0);
    check_res("f7777", 196, 0, 63, 1);
    step();
    feed_frame('{0, 0, 0, 0}, 0);
    check_res("f0000", 0, 0, 0, 0);
    step();
    feed_frame('{7, 7, 0, 0}, 0);
    check_res("f7700", 98, 0, 63, 1);
    step();
    feed_frame('{1, 1, 1, 1}, 0);
    check_res("f1111", 4, 0, 4, 0);
    step();

    // Backpressure with ignored operands during the stall.
    out_ready = 1'b0;
    feed_frame('{3, 3, 3, 3}, 0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 3'd7;
      step();
      chk("stall_vld", int'(bus8.out_valid), 1);
      chk("stall_sum", int'(bus8.out_sum), 36);
      chk("stall_rdy", int'(bus8.in_ready), 0);
      chk("stall_cnt", int'(cnt8), 4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rel_vld", int'(bus8.out_valid), 0);
    chk("rel_hold", int'(bus8.out_sum), 36);
    feed_frame('{2, 2, 2, 2}, 0);
    check_res("f2222", 16, 0, 16, 0);
    step();

    // Gaps between operands.
    feed_frame('{1, 2, 3, 7}, 2);
    check_res("gap", 63, 0, 63, 0);
    step();

    // Abort mid-frame.
    feed_frame_partial();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnt", int'(cnt8), 0);
    feed_frame('{1, 1, 1, 1}, 0);
    check_res("clr", 4, 0, 4, 0);
    step();

    // Abort while a result is pending.
    out_ready = 1'b0;
    feed_frame('{6, 6, 6, 6}, 0);
    check_res("f6666", 144, 0, 63, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    out_ready = 1'b1;
    chk("clrh_vld", int'(bus8.out_valid), 0);
    chk("clrh_rdy", int'(bus8.in_ready), 1);

    // Asynchronous reset mid-frame.
    feed_one(2, 0);
    feed_one(2, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", int'(cnt8), 0);
    chk("arst_vld", int'(bus8.out_valid), 0);
    step();
    rst = 1'b0;
    step();

    // Asynchronous reset while holding a result.
    out_ready = 1'b0;
    feed_frame('{4, 4, 4, 4}, 0);
    chk("hold_vld", int'(bus8.out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("hrst_vld", int'(bus8.out_valid), 0);
    chk("hrst_cnt", int'(cnt8), 0);
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    feed_frame('{5, 0, 0, 0}, 0);
    check_res("f5000", 25, 0, 25, 0);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  task automatic feed_frame_partial();
    feed_one(3, 0);
    feed_one(3, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
